mem_arbiter: RTL and testbench
==============================

Name: mem_arbiter

Overview:
- Shares the single external word-granular memory port between the instruction cache and the data cache.
- Grants the port to one cache at a time and tracks outstanding reads so responses return to the issuer.
- Holds a grant across a whole line fill, then releases it using round-robin fairness.
- Sits between the two cache instances and the top-level memory interface.

Parameters:
- MAX_OUT, 4: maximum outstanding reads per grant; counter width is clog2(MAX_OUT+1).
- HOLD, 2: consecutive idle cycles (no request, zero outstanding) before the owner's grant is released; legal range 1..15.

Ports:
- i_clk  in  1  clock
- i_rst  in  1  reset
- i_ic_req  in  1  icache wants the memory (level, held through the fill)
- i_ic_addr  in  32  icache word address
- i_ic_ren  in  1  icache read strobe
- o_ic_ready  out  1  memory ready, gated to icache
- o_ic_rdata  out  32  read data to icache
- o_ic_valid  out  1  read response to icache
- i_dc_req, i_dc_addr, i_dc_ren  in  1/32/1  same as icache
- i_dc_wen  in  1  dcache write strobe
- i_dc_wdata  in  32  dcache write data
- o_dc_ready, o_dc_rdata, o_dc_valid  out  1/32/1  same as icache
- i_mem_ready  in  1  backing memory can accept a request
- o_mem_addr  out  32  muxed address
- o_mem_ren  out  1  muxed read strobe
- o_mem_wen  out  1  muxed write strobe
- o_mem_wdata  out  32  dcache write data
- i_mem_rdata  in  32  memory read data
- i_mem_valid  in  1  memory read response

Behaviour:
- Reset is i_rst, synchronous, active-high; clock is i_clk.
  - On reset: state IDLE, no owner, outstanding count 0, idle counter 0, last_owner = DC (so icache wins the first tie).
  - All strobe, ready and valid outputs are 0 while in reset.
- State machine: IDLE, OWN_IC, OWN_DC.
  - IDLE:
    - Only one request asserted: grant goes to it.
    - Both asserted: grant goes to the requester that is not last_owner.
    - The grant is registered. The owner sees o_x_ready one cycle after the req it raised from IDLE.
    - last_owner updates at grant.
  - OWN_x:
    - o_x_ready = i_mem_ready. The other cache's ready is 0.
    - o_mem_addr, o_mem_ren, o_mem_wen and o_mem_wdata follow the owner's inputs combinationally.
    - Non-owner strobes are ignored and never reach memory.
- Outstanding count:
  - Increments when o_mem_ren & i_mem_ready.
  - Decrements on i_mem_valid.
  - Simultaneous increment and decrement leaves it unchanged.
  - Writes do not produce valid and are not counted.
- Owner read strobe with count == MAX_OUT: blocked (o_mem_ren forced 0, o_x_ready forced 0).
- Response routing:
  - i_mem_valid and i_mem_rdata go to the owner's o_x_valid and o_x_rdata in the same cycle.
  - The non-owner's valid stays 0; its rdata mirrors i_mem_rdata and carries no meaning.
- Idle counter:
  - Counts cycles with owner req=0, no strobe and count==0.
  - Clears on any owner activity.
  - Reaching HOLD sends the FSM to IDLE.
  - Owner req=1 blocks release even between fill words.
- Re-grant: the cycle after entering IDLE, the round-robin choice applies, so an alternating requester wins.
- Stray i_mem_valid with count==0 or no owner: dropped, count stays at 0 (no underflow).
- Reset mid-fill: the grant is dropped immediately. Valids returned later are discarded.
- Strobe from a non-owner while it has req=1: no effect; it waits for its grant.

Optional Feature:
- MEM_ARB_DCACHE_PRIO_EN defined: arbitration in IDLE is fixed priority and dcache always wins ties. last_owner is still maintained but unused.
- Undefined: round-robin as above.

Test Plan:
- Reset, then i_ic_req=1 and 4 reads to 0x100..0x10C, memory latency 2 → OWN_IC; 4 o_ic_valid pulses with data 0xA0..0xA3; o_dc_valid stays 0; release HOLD=2 cycles after the last valid with req dropped.
- Both reqs raised in the same cycle from reset → icache granted first. After its release, dcache is granted in the next IDLE; a third contention goes back to icache.
- Dcache write hit: i_dc_wen, addr 0x2004, wdata 0xDEADBEEF → o_mem_wen=1 with the same addr/data; count stays 0; no valid expected.
- MAX_OUT=4 with 5 back-to-back icache reads and no valids → fifth read blocked (o_mem_ren=0, o_ic_ready=0) until the first valid arrives.
- i_rst asserted with 2 reads outstanding, then 2 valids arrive → both dropped; no o_x_valid; count 0; state IDLE.
- MEM_ARB_DCACHE_PRIO_EN defined and both reqs contend 3 times → dcache granted each time.

Source files
------------

// File: rtl/mem_arbiter.sv
// rtl/mem_arbiter.sv - shares one word-granular memory port between icache and dcache
// Optional MEM_ARB_DCACHE_PRIO_EN: fixed dcache-wins arbitration instead of round-robin.
module mem_arbiter #(
    parameter int MAX_OUT = 4,
    parameter int HOLD    = 2
) (
    input  logic        i_clk,
    input  logic        i_rst,
    input  logic        i_ic_req,
    input  logic [31:0] i_ic_addr,
    input  logic        i_ic_ren,
    output logic        o_ic_ready,
    output logic [31:0] o_ic_rdata,
    output logic        o_ic_valid,
    input  logic        i_dc_req,
    input  logic [31:0] i_dc_addr,
    input  logic        i_dc_ren,
    input  logic        i_dc_wen,
    input  logic [31:0] i_dc_wdata,
    output logic        o_dc_ready,
    output logic [31:0] o_dc_rdata,
    output logic        o_dc_valid,
    input  logic        i_mem_ready,
    output logic [31:0] o_mem_addr,
    output logic        o_mem_ren,
    output logic        o_mem_wen,
    output logic [31:0] o_mem_wdata,
    input  logic [31:0] i_mem_rdata,
    input  logic        i_mem_valid
);
    localparam int CW = $clog2(MAX_OUT + 1);

    typedef enum logic [1:0] {IDLE, OWN_IC, OWN_DC} state_t;

    state_t        state_q, state_d;
    logic          last_dc_q, last_dc_d;
    logic [CW-1:0] out_cnt_q, out_cnt_d;
    logic [3:0]    idle_cnt_q, idle_cnt_d;

    logic own_ic, own_dc, own_req, own_ren, own_wen;
    logic full, rd_accept, rsp, pick_dc;

    // Datapath: ownership is gated by reset so a mid-fill reset drops the grant at once.
    always_comb begin
        own_ic      = (state_q == OWN_IC) && !i_rst;
        own_dc      = (state_q == OWN_DC) && !i_rst;
        own_req     = (state_q == OWN_IC) ? i_ic_req : i_dc_req;
        own_ren     = (own_ic && i_ic_ren) || (own_dc && i_dc_ren);
        own_wen     = own_dc && i_dc_wen;
        full        = own_ren && (out_cnt_q == CW'(MAX_OUT));
        o_mem_ren   = own_ren && !full;
        o_mem_wen   = own_wen;
        o_mem_addr  = own_dc ? i_dc_addr : i_ic_addr;
        o_mem_wdata = i_dc_wdata;
        o_ic_ready  = own_ic && i_mem_ready && !full;
        o_dc_ready  = own_dc && i_mem_ready && !full;
        rd_accept   = o_mem_ren && i_mem_ready;
        // Stray responses (nothing outstanding or no owner) are swallowed here.
        rsp         = i_mem_valid && (out_cnt_q != '0) && (own_ic || own_dc);
        o_ic_valid  = own_ic && rsp;
        o_dc_valid  = own_dc && rsp;
        o_ic_rdata  = i_mem_rdata;
        o_dc_rdata  = i_mem_rdata;
    end

    always_comb begin
        out_cnt_d = out_cnt_q;
        if (rd_accept && !rsp) begin
            out_cnt_d = out_cnt_q + CW'(1);
        end else if (!rd_accept && rsp) begin
            out_cnt_d = out_cnt_q - CW'(1);
        end
    end

    always_comb begin
        state_d    = state_q;
        last_dc_d  = last_dc_q;
        idle_cnt_d = idle_cnt_q;
        pick_dc    = i_dc_req;
        case (state_q)
            IDLE: begin
                idle_cnt_d = '0;
                if (i_ic_req && i_dc_req) begin
`ifdef MEM_ARB_DCACHE_PRIO_EN
                    pick_dc = 1'b1;
`else
                    pick_dc = !last_dc_q;
`endif
                end
                if (i_ic_req || i_dc_req) begin
                    state_d   = pick_dc ? OWN_DC : OWN_IC;
                    last_dc_d = pick_dc;
                end
            end
            OWN_IC, OWN_DC: begin
                // A raised req keeps the grant even while waiting between fill words.
                if (!own_req && !own_ren && !own_wen && (out_cnt_q == '0)) begin
                    if (idle_cnt_q + 4'd1 == 4'(HOLD)) begin
                        state_d    = IDLE;
                        idle_cnt_d = '0;
                    end else begin
                        idle_cnt_d = idle_cnt_q + 4'd1;
                    end
                end else begin
                    idle_cnt_d = '0;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state_q    <= IDLE;
            last_dc_q  <= 1'b1;
            out_cnt_q  <= '0;
            idle_cnt_q <= '0;
        end else begin
            state_q    <= state_d;
            last_dc_q  <= last_dc_d;
            out_cnt_q  <= out_cnt_d;
            idle_cnt_q <= idle_cnt_d;
        end
    end
endmodule

// File: tb/tb_mem_arbiter.sv
// tb/tb_mem_arbiter.sv - directed bench for mem_arbiter with a per-cycle ownership model
module tb_mem_arbiter;
    localparam int MAX_OUT = 4;
    localparam int HOLD    = 2;
`ifdef MEM_ARB_DCACHE_PRIO_EN
    localparam bit PRIO = 1'b1;
`else
    localparam bit PRIO = 1'b0;
`endif

    logic        i_clk = 1'b0;
    logic        i_rst = 1'b1;
    logic        i_ic_req = 1'b0, i_ic_ren = 1'b0;
    logic [31:0] i_ic_addr = '0;
    logic        i_dc_req = 1'b0, i_dc_ren = 1'b0, i_dc_wen = 1'b0;
    logic [31:0] i_dc_addr = '0, i_dc_wdata = '0;
    logic        i_mem_ready = 1'b1, i_mem_valid = 1'b0;
    logic [31:0] i_mem_rdata = '0;
    logic        o_ic_ready, o_ic_valid, o_dc_ready, o_dc_valid, o_mem_ren, o_mem_wen;
    logic [31:0] o_ic_rdata, o_dc_rdata, o_mem_addr, o_mem_wdata;

    mem_arbiter #(.MAX_OUT(MAX_OUT), .HOLD(HOLD)) dut (
        .i_clk(i_clk), .i_rst(i_rst),
        .i_ic_req(i_ic_req), .i_ic_addr(i_ic_addr), .i_ic_ren(i_ic_ren),
        .o_ic_ready(o_ic_ready), .o_ic_rdata(o_ic_rdata), .o_ic_valid(o_ic_valid),
        .i_dc_req(i_dc_req), .i_dc_addr(i_dc_addr), .i_dc_ren(i_dc_ren),
        .i_dc_wen(i_dc_wen), .i_dc_wdata(i_dc_wdata),
        .o_dc_ready(o_dc_ready), .o_dc_rdata(o_dc_rdata), .o_dc_valid(o_dc_valid),
        .i_mem_ready(i_mem_ready), .o_mem_addr(o_mem_addr), .o_mem_ren(o_mem_ren),
        .o_mem_wen(o_mem_wen), .o_mem_wdata(o_mem_wdata),
        .i_mem_rdata(i_mem_rdata), .i_mem_valid(i_mem_valid)
    );

    always #5 i_clk = ~i_clk;

    int tests = 0, fails = 0;
    int cyc = 0;
    int lat = 2;
    bit chk_en = 1'b0;
    int last_ic_val_cyc = 0;

    typedef struct {
        logic [31:0] addr;
        int          due;
    } rd_t;
    rd_t         rq[$];
    logic [31:0] ic_got[$];
    logic [31:0] dc_got[$];

    // Model: owner 0=none 1=icache 2=dcache; last 1/2; outstanding reads; idle cycles.
    int          m_owner = 0, m_last = 2, m_out = 0, m_idle = 0;
    int          ow_req, ow_ren, ow_wen, full, win;
    logic [31:0] ow_addr;
    logic        e_ic_rdy, e_dc_rdy, e_ren, e_wen, e_ic_val, e_dc_val;

    int          s_cyc;
    logic        s_ic_rdy, s_dc_rdy, s_ren, s_wen;
    logic [31:0] s_addr, s_wdata;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic tmo(input string name);
        tests++;
        fails++;
        $display("FAIL %s: timed out at cycle %0d", name, cyc);
    endtask

    always @(negedge i_clk) begin
        if (chk_en) begin
            e_ic_rdy = 0; e_dc_rdy = 0; e_ren = 0; e_wen = 0; e_ic_val = 0; e_dc_val = 0;
            ow_req = 0; ow_ren = 0; ow_wen = 0; ow_addr = '0; full = 0;
            if (!i_rst && m_owner != 0) begin
                if (m_owner == 1) begin
                    ow_req = i_ic_req; ow_ren = i_ic_ren; ow_addr = i_ic_addr;
                end else begin
                    ow_req = i_dc_req; ow_ren = i_dc_ren; ow_wen = i_dc_wen; ow_addr = i_dc_addr;
                end
                full     = (ow_ren != 0 && m_out == MAX_OUT) ? 1 : 0;
                e_ren    = (ow_ren != 0) && (full == 0);
                e_wen    = (ow_wen != 0);
                e_ic_rdy = (m_owner == 1) && i_mem_ready && (full == 0);
                e_dc_rdy = (m_owner == 2) && i_mem_ready && (full == 0);
                e_ic_val = (m_owner == 1) && i_mem_valid && (m_out > 0);
                e_dc_val = (m_owner == 2) && i_mem_valid && (m_out > 0);
            end
            chk("ic_ready", o_ic_ready, e_ic_rdy);
            chk("dc_ready", o_dc_ready, e_dc_rdy);
            chk("mem_ren", o_mem_ren, e_ren);
            chk("mem_wen", o_mem_wen, e_wen);
            chk("ic_valid", o_ic_valid, e_ic_val);
            chk("dc_valid", o_dc_valid, e_dc_val);
            if (e_ren || e_wen) chk("mem_addr", o_mem_addr, ow_addr);
            if (e_wen) chk("mem_wdata", o_mem_wdata, i_dc_wdata);
            if (e_ic_val) chk("ic_rdata", o_ic_rdata, i_mem_rdata);
            if (e_dc_val) chk("dc_rdata", o_dc_rdata, i_mem_rdata);

            if (i_rst) begin
                m_owner = 0; m_last = 2; m_out = 0; m_idle = 0;
            end else if (m_owner == 0) begin
                win = 0;
                if (i_ic_req && i_dc_req) win = PRIO ? 2 : ((m_last == 2) ? 1 : 2);
                else if (i_ic_req) win = 1;
                else if (i_dc_req) win = 2;
                if (win != 0) begin
                    m_owner = win;
                    m_last  = win;
                end
                m_idle = 0;
            end else begin
                if (ow_req == 0 && ow_ren == 0 && ow_wen == 0 && m_out == 0) m_idle++;
                else m_idle = 0;
                m_out = m_out + ((e_ren && i_mem_ready) ? 1 : 0) - ((e_ic_val || e_dc_val) ? 1 : 0);
                if (m_idle == HOLD) begin
                    m_owner = 0;
                    m_idle  = 0;
                end
            end
        end
        if (o_mem_ren && i_mem_ready) rq.push_back('{o_mem_addr, cyc + lat});
        if (o_ic_valid) begin
            ic_got.push_back(o_ic_rdata);
            last_ic_val_cyc = cyc;
        end
        if (o_dc_valid) dc_got.push_back(o_dc_rdata);
    end

    // Backing memory: fixed latency, one response per cycle, data derived from address.
    always @(posedge i_clk) begin
        cyc++;
        #1;
        if (rq.size() > 0 && rq[0].due <= cyc) begin
            i_mem_valid = 1'b1;
            i_mem_rdata = 32'hA0 + ((rq[0].addr - 32'h100) >> 2);
            void'(rq.pop_front());
        end else begin
            i_mem_valid = 1'b0;
            i_mem_rdata = 32'h5A5A0000 + cyc;
        end
    end

    task automatic step();
        @(negedge i_clk);
        s_cyc    = cyc;
        s_ic_rdy = o_ic_ready;
        s_dc_rdy = o_dc_ready;
        s_ren    = o_mem_ren;
        s_wen    = o_mem_wen;
        s_addr   = o_mem_addr;
        s_wdata  = o_mem_wdata;
        @(posedge i_clk);
        #1;
    endtask

    task automatic do_reset(input int n);
        i_rst = 1'b1;
        i_ic_req = 0; i_ic_ren = 0; i_dc_req = 0; i_dc_ren = 0; i_dc_wen = 0;
        i_mem_ready = 1'b1;
        repeat (n) step();
        i_rst = 1'b0;
    endtask

    task automatic ic_read_seq(input logic [31:0] base, input int n, output int first, output int last);
        int k = 0;
        int g = 0;
        first = 0;
        last  = 0;
        i_ic_ren  = 1'b1;
        i_ic_addr = base;
        while (k < n && g < 100) begin
            step();
            g++;
            if (s_ic_rdy) begin
                if (k == 0) first = s_cyc;
                last = s_cyc;
                k++;
                i_ic_addr = base + 32'(4 * k);
            end
        end
        i_ic_ren = 1'b0;
        if (k < n) tmo("ic_read_seq");
    endtask

    task automatic wait_ic(input int n);
        int g = 0;
        while (ic_got.size() < n && g < 60) begin
            step();
            g++;
        end
        if (ic_got.size() < n) tmo("wait_ic_valid");
    endtask

    initial begin
        int f, l, t_last, w, got;
        int exp_w[3];
        chk_en = 1'b1;

        // Reset state
        do_reset(3);
        chk("rst_ic_ready", s_ic_rdy, 0);
        chk("rst_mem_ren", s_ren, 0);
        chk("model_rst_last", m_last, 2);
        chk("model_rst_out", m_out, 0);

        // Icache line fill, latency 2, then release
        lat = 2;
        ic_got.delete();
        dc_got.delete();
        i_ic_req = 1'b1;
        ic_read_seq(32'h100, 4, f, l);
        chk("fill_back_to_back", l - f, 3);
        wait_ic(4);
        chk("fill_count", ic_got.size(), 4);
        if (ic_got.size() == 4) begin
            chk("fill_d0", ic_got[0], 32'hA0);
            chk("fill_d1", ic_got[1], 32'hA1);
            chk("fill_d2", ic_got[2], 32'hA2);
            chk("fill_d3", ic_got[3], 32'hA3);
        end
        chk("fill_dc_valids", dc_got.size(), 0);
        t_last   = last_ic_val_cyc;
        i_ic_req = 1'b0;
        i_dc_req = 1'b1;
        got = 0;
        for (int k = 0; k < 10 && got == 0; k++) begin
            step();
            if (s_dc_rdy) got = 1;
        end
        if (got == 0) tmo("release_grant");
        else chk("release_cycle", s_cyc, t_last + 4);
        i_dc_req = 1'b0;
        repeat (3) step();

        // Three contentions from reset
        do_reset(2);
        exp_w[0] = 1; exp_w[1] = 2; exp_w[2] = 1;
        if (PRIO) begin
            exp_w[0] = 2; exp_w[1] = 2; exp_w[2] = 2;
        end
        i_ic_req = 1'b1;
        i_dc_req = 1'b1;
        for (int r = 0; r < 3; r++) begin
            w = 0;
            for (int k = 0; k < 10 && w == 0; k++) begin
                step();
                if (s_ic_rdy) w = 1;
                else if (s_dc_rdy) w = 2;
            end
            if (w == 0) tmo("contention_grant");
            chk($sformatf("contention_%0d", r), w, exp_w[r]);
            if (w == 1) i_ic_req = 1'b0;
            else i_dc_req = 1'b0;
            repeat (HOLD) step();
            i_ic_req = 1'b1;
            i_dc_req = 1'b1;
        end
        i_ic_req = 1'b0;
        i_dc_req = 1'b0;

        // Dcache write with memory stall and a non-owner icache strobe
        do_reset(2);
        dc_got.delete();
        i_dc_req = 1'b1;
        step();
        i_dc_wen    = 1'b1;
        i_dc_addr   = 32'h2004;
        i_dc_wdata  = 32'hDEADBEEF;
        i_ic_req    = 1'b1;
        i_ic_ren    = 1'b1;
        i_ic_addr   = 32'h300;
        i_mem_ready = 1'b0;
        repeat (2) step();
        chk("stall_dc_ready", s_dc_rdy, 0);
        i_mem_ready = 1'b1;
        step();
        chk("wr_dc_ready", s_dc_rdy, 1);
        chk("wr_mem_wen", s_wen, 1);
        chk("wr_mem_ren", s_ren, 0);
        chk("wr_mem_addr", s_addr, 32'h2004);
        chk("wr_mem_wdata", s_wdata, 32'hDEADBEEF);
        i_dc_wen = 1'b0;
        i_dc_req = 1'b0;
        i_ic_req = 1'b0;
        i_ic_ren = 1'b0;
        repeat (4) step();
        chk("wr_no_valid", dc_got.size(), 0);
        chk("model_wr_out", m_out, 0);
        i_ic_req = 1'b1;
        repeat (2) step();
        chk("after_wr_ic_grant", s_ic_rdy, 1);
        i_ic_req = 1'b0;

        // Outstanding limit: fifth read waits for the first response
        do_reset(2);
        lat = 8;
        ic_got.delete();
        i_ic_req = 1'b1;
        ic_read_seq(32'h100, 5, f, l);
        chk("max_out_fifth_accept", l - f, 9);
        wait_ic(5);
        if (ic_got.size() == 5) chk("max_out_d4", ic_got[4], 32'hA4);
        i_ic_req = 1'b0;
        repeat (3) step();

        // Reset with two reads in flight
        do_reset(2);
        lat = 4;
        ic_got.delete();
        dc_got.delete();
        i_ic_req = 1'b1;
        ic_read_seq(32'h100, 2, f, l);
        chk("rst_fill_accepts", l - f, 1);
        i_ic_req = 1'b0;
        i_rst = 1'b1;
        step();
        i_rst = 1'b0;
        repeat (6) step();
        chk("rst_fill_ic_dropped", ic_got.size(), 0);
        chk("rst_fill_dc_dropped", dc_got.size(), 0);
        chk("model_rst_fill_out", m_out, 0);
        i_dc_req = 1'b1;
        repeat (2) step();
        chk("rst_fill_idle_regrant", s_dc_rdy, 1);
        i_dc_req = 1'b0;
        repeat (3) step();

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end
endmodule
